// File: rtl/cp0_timer_irq.sv
// rtl/cp0_timer_irq.sv - CP0 register file with COUNT/COMPARE timer, interrupts and exception sequencing
module cp0_timer_irq #(
    parameter int          IRQ_LINES   = 6,
    parameter int          COUNT_DIV   = 1,
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_3000,
    parameter logic [31:0] BOOT_VECTOR = 32'hBFC0_0380
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           reg_num,
    input  logic [2:0]           reg_sel,
    input  logic [31:0]          in_data,
    input  logic                 reg_wr,
    input  logic                 reg_rd,
    input  logic [2:0]           cop_op,
    input  logic [31:0]          next_pc,
    input  logic [31:0]          int_pc,
    input  logic [19:0]          code,
    input  logic [IRQ_LINES-1:0] irq,
    input  logic                 take_int,
    output logic [31:0]          out_data,
    output logic                 int_req,
    output logic                 redirect,
    output logic [31:0]          redirect_pc
);

    // Encodings shared with the decode stage (common.v).
    localparam logic [2:0] COP_OP_MV  = 3'd1;
    localparam logic [2:0] COP_OP_EN  = 3'd2;
    localparam logic [2:0] COP_OP_DIS = 3'd3;
    localparam logic [2:0] COP_OP_RET = 3'd4;
    localparam logic [2:0] COP_OP_SYS = 3'd5;
    localparam logic [2:0] COP_OP_BRK = 3'd6;

    localparam logic [4:0] REG_COUNT     = 5'd9;
    localparam logic [4:0] REG_COMPARE   = 5'd11;
    localparam logic [4:0] REG_STATUS    = 5'd12;
    localparam logic [4:0] REG_CAUSE     = 5'd13;
    localparam logic [4:0] REG_EPC       = 5'd14;
    localparam logic [4:0] REG_ERROR_EPC = 5'd30;

    localparam logic [31:0] STATUS_MASK  = 32'h0040_FF17;
    localparam logic [31:0] STATUS_RESET = 32'h0000_FF01;
    localparam logic [7:0]  PRESC_LAST   = 8'(COUNT_DIV - 1);

    logic [31:0]          status_q, status_d;
    logic [31:0]          count_q, count_d;
    logic [31:0]          compare_q, compare_d;
    logic [31:0]          epc_q, epc_d;
    logic [31:0]          error_epc_q, error_epc_d;
    logic [4:0]           exccode_q, exccode_d;
    logic [1:0]           ip_sw_q, ip_sw_d;
    logic                 ti_q, ti_d;
    logic [7:0]           presc_q, presc_d;
    logic [IRQ_LINES-1:0] irq_q;
    logic                 redirect_q, redirect_d;
    logic [31:0]          redirect_pc_q, redirect_pc_d;

    logic [5:0]  irq_ext;
    logic [7:0]  ip;
    logic [31:0] cause;
    logic [31:0] vector;
    logic        take_now;
    logic        mv_wr;
    logic        tick;
    logic        unused_code;

    assign unused_code = ^code;

    generate
        if (IRQ_LINES < 6) begin : g_pad_irq
            assign irq_ext = {{(6 - IRQ_LINES){1'b0}}, irq_q};
        end else begin : g_full_irq
            assign irq_ext = irq_q;
        end
    endgenerate

    // The timer interrupt shares IP[7] with the top external line.
    assign ip      = {irq_ext[5] | ti_q, irq_ext[4:0], ip_sw_q};
    assign cause   = {1'b0, ti_q, 14'b0, ip, 1'b0, exccode_q, 2'b00};
    assign vector  = status_q[22] ? BOOT_VECTOR : EXC_VECTOR;
    assign int_req = status_q[0] & ~status_q[1] & ~status_q[2] & (|(ip & status_q[15:8]));

    assign take_now = take_int & int_req;
    assign mv_wr    = ~take_now & (cop_op == COP_OP_MV) & reg_wr & (reg_sel == 3'd0);
    assign tick     = (presc_q == PRESC_LAST);

    always_comb begin
        out_data = 32'h0;
        if (cop_op == COP_OP_MV && reg_rd && reg_sel == 3'd0) begin
            case (reg_num)
                REG_COUNT:     out_data = count_q;
                REG_COMPARE:   out_data = compare_q;
                REG_STATUS:    out_data = status_q;
                REG_CAUSE:     out_data = cause;
                REG_EPC:       out_data = epc_q;
                REG_ERROR_EPC: out_data = error_epc_q;
                default:       out_data = 32'h0;
            endcase
        end else if (cop_op == COP_OP_EN || cop_op == COP_OP_DIS) begin
            out_data = status_q;
        end
    end

    always_comb begin
        status_d      = status_q;
        count_d       = count_q;
        compare_d     = compare_q;
        epc_d         = epc_q;
        error_epc_d   = error_epc_q;
        exccode_d     = exccode_q;
        ip_sw_d       = ip_sw_q;
        ti_d          = ti_q;
        presc_d       = tick ? 8'd0 : presc_q + 8'd1;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;

        if (tick) begin
            count_d = count_q + 32'd1;
            if (count_q + 32'd1 == compare_q) begin
                ti_d = 1'b1;
            end
        end

        if (mv_wr) begin
            case (reg_num)
                REG_COUNT: begin
                    count_d = in_data;
                    presc_d = 8'd0;
                end
                REG_COMPARE: begin
                    compare_d = in_data;
                    ti_d      = 1'b0;
                end
                REG_STATUS:    status_d    = in_data & STATUS_MASK;
                REG_CAUSE:     ip_sw_d     = in_data[9:8];
                REG_EPC:       epc_d       = in_data;
                REG_ERROR_EPC: error_epc_d = in_data;
                default: ;
            endcase
        end

        // An accepted interrupt swallows whatever op arrived alongside it.
        if (take_now) begin
            epc_d         = int_pc;
            exccode_d     = 5'd0;
            status_d[1]   = 1'b1;
            redirect_d    = 1'b1;
            redirect_pc_d = vector;
        end else begin
            case (cop_op)
                COP_OP_EN:  status_d[0] = 1'b1;
                COP_OP_DIS: status_d[0] = 1'b0;
                COP_OP_RET: begin
                    redirect_d = 1'b1;
                    if (status_q[2]) begin
                        redirect_pc_d = error_epc_q;
                        status_d[2]   = 1'b0;
                    end else begin
                        redirect_pc_d = epc_q;
                        status_d[1]   = 1'b0;
                    end
                end
                COP_OP_SYS, COP_OP_BRK: begin
                    epc_d         = next_pc;
                    exccode_d     = (cop_op == COP_OP_SYS) ? 5'd8 : 5'd9;
                    status_d[1]   = 1'b1;
                    redirect_d    = 1'b1;
                    redirect_pc_d = vector;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q      <= STATUS_RESET;
            count_q       <= 32'h0;
            compare_q     <= 32'h0;
            epc_q         <= 32'h0;
            error_epc_q   <= 32'h0;
            exccode_q     <= 5'd0;
            ip_sw_q       <= 2'b00;
            ti_q          <= 1'b0;
            presc_q       <= 8'd0;
            irq_q         <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'h0;
        end else begin
            status_q      <= status_d;
            count_q       <= count_d;
            compare_q     <= compare_d;
            epc_q         <= epc_d;
            error_epc_q   <= error_epc_d;
            exccode_q     <= exccode_d;
            ip_sw_q       <= ip_sw_d;
            ti_q          <= ti_d;
            presc_q       <= presc_d;
            irq_q         <= irq;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_cp0_timer_irq.sv
// tb/tb_cp0_timer_irq.sv - directed self-checking bench for cp0_timer_irq
module tb_cp0_timer_irq;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_MV  = 3'd1;
    localparam logic [2:0] OP_EN  = 3'd2;
    localparam logic [2:0] OP_DIS = 3'd3;
    localparam logic [2:0] OP_RET = 3'd4;
    localparam logic [2:0] OP_SYS = 3'd5;
    localparam logic [2:0] OP_BRK = 3'd6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  reg_num = '0;
    logic [2:0]  reg_sel = '0;
    logic [31:0] in_data = '0;
    logic        reg_wr = 1'b0;
    logic        reg_rd = 1'b0;
    logic [2:0]  cop_op = OP_NOP;
    logic [31:0] next_pc = '0;
    logic [31:0] int_pc = '0;
    logic [19:0] code = '0;
    logic [5:0]  irq = '0;
    logic        take_int = 1'b0;
    logic [31:0] out_data;
    logic        int_req;
    logic        redirect;
    logic [31:0] redirect_pc;

    int n_checks = 0;
    int n_fail   = 0;

    cp0_timer_irq dut (
        .clk(clk), .rst(rst), .reg_num(reg_num), .reg_sel(reg_sel),
        .in_data(in_data), .reg_wr(reg_wr), .reg_rd(reg_rd), .cop_op(cop_op),
        .next_pc(next_pc), .int_pc(int_pc), .code(code), .irq(irq),
        .take_int(take_int), .out_data(out_data), .int_req(int_req),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] num, input logic [31:0] data);
        cop_op = OP_MV; reg_num = num; reg_sel = 3'd0; in_data = data; reg_wr = 1'b1;
        step(1);
        cop_op = OP_NOP; reg_wr = 1'b0;
    endtask

    task automatic mfc0(input string tag, input logic [4:0] num, input logic [2:0] sel,
                        input logic [31:0] exp);
        cop_op = OP_MV; reg_num = num; reg_sel = sel; reg_rd = 1'b1;
        #1;
        check(tag, out_data, exp);
        cop_op = OP_NOP; reg_rd = 1'b0; reg_sel = 3'd0;
    endtask

    task automatic op(input logic [2:0] o, input logic [31:0] npc);
        cop_op = o; next_pc = npc;
        step(1);
        cop_op = OP_NOP;
    endtask

    initial begin
        step(3);
        rst = 1'b0;
        step(1);

        check("rst_redirect", {31'b0, redirect}, 32'h0);
        check("rst_int_req", {31'b0, int_req}, 32'h0);
        mfc0("rst_status", 5'd12, 3'd0, 32'h0000_FF01);
        mfc0("rst_reg5", 5'd5, 3'd0, 32'h0);
        mfc0("status_sel1", 5'd12, 3'd1, 32'h0);

        mtc0(5'd11, 32'd10);
        mtc0(5'd9, 32'd0);
        step(9);
        mfc0("count_9", 5'd9, 3'd0, 32'd9);
        mfc0("cause_pre_ti", 5'd13, 3'd0, 32'h0);
        step(1);
        mfc0("count_10", 5'd9, 3'd0, 32'd10);
        mfc0("cause_ti", 5'd13, 3'd0, 32'h4000_8000);
        check("int_req_ti", {31'b0, int_req}, 32'h1);
        mtc0(5'd11, 32'h1000_0000);
        mfc0("cause_ti_clr", 5'd13, 3'd0, 32'h0);
        check("int_req_ti_clr", {31'b0, int_req}, 32'h0);

        op(OP_SYS, 32'h100);
        check("sys_redirect", {31'b0, redirect}, 32'h1);
        check("sys_pc", redirect_pc, 32'h0000_3000);
        mfc0("sys_epc", 5'd14, 3'd0, 32'h100);
        mfc0("sys_cause", 5'd13, 3'd0, 32'h20);
        mfc0("sys_status", 5'd12, 3'd0, 32'h0000_FF03);
        step(1);
        check("sys_pulse_end", {31'b0, redirect}, 32'h0);
        op(OP_RET, 32'h0);
        check("ret_redirect", {31'b0, redirect}, 32'h1);
        check("ret_pc", redirect_pc, 32'h100);
        mfc0("ret_status", 5'd12, 3'd0, 32'h0000_FF01);

        irq = 6'b000001;
        #1;
        check("irq_lat0", {31'b0, int_req}, 32'h0);
        step(1);
        check("irq_lat1", {31'b0, int_req}, 32'h1);
        mfc0("irq_cause", 5'd13, 3'd0, 32'h420);
        take_int = 1'b1; int_pc = 32'h40;
        step(1);
        take_int = 1'b0;
        check("take_redirect", {31'b0, redirect}, 32'h1);
        check("take_pc", redirect_pc, 32'h0000_3000);
        mfc0("take_epc", 5'd14, 3'd0, 32'h40);
        mfc0("take_cause", 5'd13, 3'd0, 32'h400);
        check("take_int_req", {31'b0, int_req}, 32'h0);
        op(OP_RET, 32'h0);
        check("ret2_pc", redirect_pc, 32'h40);
        check("ret2_int_req", {31'b0, int_req}, 32'h1);

        cop_op = OP_DIS;
        #1;
        check("di_out", out_data, 32'h0000_FF01);
        step(1);
        cop_op = OP_NOP;
        check("di_int_req", {31'b0, int_req}, 32'h0);
        cop_op = OP_EN;
        #1;
        check("ei_out", out_data, 32'h0000_FF00);
        step(1);
        cop_op = OP_NOP;
        check("ei_int_req", {31'b0, int_req}, 32'h1);

        cop_op = OP_BRK; next_pc = 32'h200; take_int = 1'b1; int_pc = 32'h80;
        step(1);
        cop_op = OP_NOP; take_int = 1'b0;
        mfc0("brk_take_epc", 5'd14, 3'd0, 32'h80);
        mfc0("brk_take_cause", 5'd13, 3'd0, 32'h400);
        check("brk_take_pc", redirect_pc, 32'h0000_3000);
        irq = 6'b0;
        op(OP_RET, 32'h0);
        mfc0("brk_ret_status", 5'd12, 3'd0, 32'h0000_FF01);

        mtc0(5'd9, 32'hFFFF_FFFF);
        mfc0("count_max", 5'd9, 3'd0, 32'hFFFF_FFFF);
        step(1);
        mfc0("count_wrap", 5'd9, 3'd0, 32'h0);

        mtc0(5'd5, 32'hFFFF_FFFF);
        mfc0("reg5_wr_ignored", 5'd5, 3'd0, 32'h0);
        mtc0(5'd30, 32'h1234_5670);
        mtc0(5'd12, 32'hFFFF_FFFF);
        mfc0("status_mask", 5'd12, 3'd0, 32'h0040_FF17);
        mtc0(5'd13, 32'hFFFF_FFFF);
        mfc0("cause_mask", 5'd13, 3'd0, 32'h0000_0300);
        check("erl_int_req", {31'b0, int_req}, 32'h0);
        mtc0(5'd12, 32'h0040_0004);
        op(OP_RET, 32'h0);
        check("eret_erl_pc", redirect_pc, 32'h1234_5670);
        mfc0("eret_erl_status", 5'd12, 3'd0, 32'h0040_0000);
        op(OP_SYS, 32'h300);
        check("bev_pc", redirect_pc, 32'hBFC0_0380);
        mfc0("bev_cause", 5'd13, 3'd0, 32'h0000_0320);

        op(OP_SYS, 32'h300);
        check("pre_rst_redirect", {31'b0, redirect}, 32'h1);
        rst = 1'b1;
        #1;
        check("rst_kill_redirect", {31'b0, redirect}, 32'h0);
        check("rst_kill_pc", redirect_pc, 32'h0);
        mfc0("rst2_status", 5'd12, 3'd0, 32'h0000_FF01);
        mfc0("rst2_cause", 5'd13, 3'd0, 32'h0);
        step(1);
        rst = 1'b0;
        step(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
